// File: rtl/blinky_ocram_arb_pkg.sv
// Shared types and defaults for the two-requester on-chip RAM arbiter.
package blinky_ocram_arb_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SLEEP = 2'd1,
      ST_WAKE  = 2'd2
   } arb_state_t;

   // Index of a requester: 0 = CPU data master, 1 = DMA master
   typedef logic req_idx_t;

endpackage

// File: rtl/blinky_ocram_rr2.sv
// Two-way round-robin grant: one-hot grant, last winner remembered so
// contention alternates between the requesters.
module blinky_ocram_rr2
   import blinky_ocram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       run,
   input  logic       advance,
   output logic [1:0] grant
);

   req_idx_t last_grant;

   always_comb begin
      grant = 2'b00;
      if (run) begin
         if (req == 2'b11) begin
            grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

   // Reset value 1 lets m0 win the first contended cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (advance) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/blinky_ocram_arbiter.sv
// Round-robin Avalon-MM arbiter with idle clock gating in front of a
// single-port RAM. Optional counters: define OCRAM_ARB_PERF_CNT_EN.
module blinky_ocram_arbiter
   import blinky_ocram_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   input  logic [DATA_W-1:0]   ram_readdata,
   output logic                ram_clken,
`ifdef OCRAM_ARB_PERF_CNT_EN
   output logic [31:0]         m0_grant_cnt,
   output logic [31:0]         m1_grant_cnt,
   output logic [31:0]         contention_cnt,
`endif
   output logic                asleep
);

   localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_TIMEOUT);
   localparam logic [CNT_W-1:0] IDLE_LAST = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

   arb_state_t       state, state_nxt;
   logic [1:0]       req;
   logic             any_req;
   logic             run;
   logic [1:0]       grant;
   req_idx_t         sel;
   logic             sel_write;
   logic             rd_pending;
   req_idx_t         rd_owner;
   logic [CNT_W-1:0] idle_cnt;
   logic [1:0]       waitreq;

   assign req     = {m1_read | m1_write, m0_read | m0_write};
   assign any_req = |req;
   assign run     = (state == ST_RUN);

   blinky_ocram_rr2 u_rr2 (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .run     (run),
      .advance (|grant),
      .grant   (grant)
   );

   // Command forwarding; write wins when read and write arrive together
   assign sel            = grant[1];
   assign sel_write      = sel ? m1_write : m0_write;
   assign ram_address    = sel ? m1_address    : m0_address;
   assign ram_byteenable = sel ? m1_byteenable : m0_byteenable;
   assign ram_writedata  = sel ? m1_writedata  : m0_writedata;
   assign ram_chipselect = (|grant) & reset_n;
   assign ram_write      = ram_chipselect & sel_write;

   assign m0_waitrequest = waitreq[0];
   assign m1_waitrequest = waitreq[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      waitreq   = 2'b11;
      ram_clken = 1'b1;
      asleep    = 1'b0;
      unique case (state)
         ST_RUN: begin
            waitreq = any_req ? ~grant : 2'b00;
            if ((IDLE_TIMEOUT != 0) && !any_req && !rd_pending && (idle_cnt == IDLE_LAST)) begin
               state_nxt = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            ram_clken = 1'b0;
            asleep    = 1'b1;
            if (any_req) begin
               state_nxt = ST_WAKE;
            end
         end
         ST_WAKE: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Read return: RAM answers exactly one cycle after the granted read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pending <= (|grant) & ~sel_write;
         if (|grant) begin
            rd_owner <= sel;
         end
      end
   end

   assign m0_readdatavalid = rd_pending & (rd_owner == 1'b0);
   assign m1_readdatavalid = rd_pending & (rd_owner == 1'b1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (!run || any_req || (IDLE_TIMEOUT == 0)) begin
         idle_cnt <= '0;
      end else if (!rd_pending && (idle_cnt != IDLE_MAX)) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

`ifdef OCRAM_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m0_grant_cnt   <= '0;
         m1_grant_cnt   <= '0;
         contention_cnt <= '0;
      end else begin
         if (grant[0]) begin
            m0_grant_cnt <= m0_grant_cnt + 32'd1;
         end
         if (grant[1]) begin
            m1_grant_cnt <= m1_grant_cnt + 32'd1;
         end
         if (run && (&req)) begin
            contention_cnt <= contention_cnt + 32'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
   a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));
`endif

endmodule

// File: tb/tb_blinky_ocram_arbiter.sv
// Directed bench for blinky_ocram_arbiter with a behavioural RAM model
// (one-cycle registered read, byte-lane writes, gated by ram_clken).
module tb_blinky_ocram_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken, asleep;
   logic [DATA_W-1:0] ram_writedata, ram_readdata;
`ifdef OCRAM_ARB_PERF_CNT_EN
   logic [31:0]       m0_grant_cnt, m1_grant_cnt, contention_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   blinky_ocram_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .IDLE_TIMEOUT (16)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .ram_address      (ram_address),
      .ram_byteenable   (ram_byteenable),
      .ram_chipselect   (ram_chipselect),
      .ram_write        (ram_write),
      .ram_writedata    (ram_writedata),
      .ram_readdata     (ram_readdata),
      .ram_clken        (ram_clken),
`ifdef OCRAM_ARB_PERF_CNT_EN
      .m0_grant_cnt     (m0_grant_cnt),
      .m1_grant_cnt     (m1_grant_cnt),
      .contention_cnt   (contention_cnt),
`endif
      .asleep           (asleep)
   );

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] ram_q;

   always_ff @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < BE_W; b++) begin
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
         end else begin
            ram_q <= mem[ram_address];
         end
      end
   end
   assign ram_readdata = ram_q;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
   endtask

   // Starts at a falling edge, holds the command until accepted, returns at
   // the falling edge after the accepting rising edge with the command removed.
   task automatic access(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                         output int waits);
      waits = 0;
      if (m == 0) begin
         m0_address = a; m0_writedata = d; m0_byteenable = be; m0_write = wr; m0_read = !wr;
      end else begin
         m1_address = a; m1_writedata = d; m1_byteenable = be; m1_write = wr; m1_read = !wr;
      end
      #1;
      while (((m == 0) ? m0_waitrequest : m1_waitrequest) && waits < 20) begin
         @(negedge clk); #1;
         waits++;
      end
      if (waits >= 20) check_vec("access_timeout", 64'(waits), 64'd0);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic read_check(input string tag, input int m, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] exp, input int exp_waits);
      int w;
      access(m, 1'b0, a, '0, '0, w);
      check_vec({tag, "_waits"}, 64'(w), 64'(exp_waits));
      check_vec({tag, "_rdv_own"}, (m == 0) ? m0_readdatavalid : m1_readdatavalid, 1);
      check_vec({tag, "_rdv_oth"}, (m == 0) ? m1_readdatavalid : m0_readdatavalid, 0);
      check_vec({tag, "_data"}, (m == 0) ? m0_readdata : m1_readdata, exp);
   endtask

   initial begin
      int w;
      int i0, i1, cyc, k, w0, w1;
      logic [7:0] order;

      reset_n = 1'b0;
      idle_inputs();
      #1;
      check_vec("rst_clken", ram_clken, 1);
      check_vec("rst_asleep", asleep, 0);
      check_vec("rst_rdv0", m0_readdatavalid, 0);
      check_vec("rst_rdv1", m1_readdatavalid, 0);
      check_vec("rst_cs", ram_chipselect, 0);
      check_vec("rst_wait0", m0_waitrequest, 0);
      check_vec("rst_wait1", m1_waitrequest, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      access(0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, w);
      check_vec("pre0_waits", 64'(w), 0);
      access(1, 1'b1, 14'h0020, 32'h11223344, 4'hF, w);
      check_vec("pre1_waits", 64'(w), 0);

      // Single read: accepted immediately, other master sees waitrequest
      m0_address = 14'h0010; m0_read = 1'b1;
      #1;
      check_vec("sr_wait0", m0_waitrequest, 0);
      check_vec("sr_wait1", m1_waitrequest, 1);
      check_vec("sr_cs", ram_chipselect, 1);
      check_vec("sr_addr", ram_address, 14'h0010);
      @(negedge clk);
      idle_inputs();
      check_vec("sr_rdv0", m0_readdatavalid, 1);
      check_vec("sr_rdv1", m1_readdatavalid, 0);
      check_vec("sr_data", m0_readdata, 32'hDEADBEEF);
      @(negedge clk);
      check_vec("sr_rdv0_pulse", m0_readdatavalid, 0);

      // Byte-lane write: lanes 0 and 2 replaced
      access(1, 1'b1, 14'h0020, 32'hAABBCCDD, 4'b0101, w);
      read_check("bw", 1, 14'h0020, 32'h11BB33DD, 0);

      // Write then read the same word on consecutive cycles
      access(0, 1'b1, 14'h0030, 32'h12345678, 4'hF, w);
      read_check("wr_rd", 0, 14'h0030, 32'h12345678, 0);

      // Reset while a read is outstanding
      m0_address = 14'h0010; m0_read = 1'b1;
      #1;
      check_vec("rm_wait0", m0_waitrequest, 0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_vec("rm_rdv0_a", m0_readdatavalid, 0);
      @(negedge clk);
      check_vec("rm_rdv0_b", m0_readdatavalid, 0);
      check_vec("rm_rdv1", m1_readdatavalid, 0);
      check_vec("rm_cs", ram_chipselect, 0);
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      check_vec("rm_rdv0_c", m0_readdatavalid, 0);
      @(negedge clk);
      check_vec("rm_rdv0_d", m0_readdatavalid, 0);

      // Contention: both masters write four words back to back
      i0 = 0; i1 = 0; cyc = 0; k = 0; w0 = 0; w1 = 0; order = '0;
      while ((i0 < 4 || i1 < 4) && cyc < 40) begin
         m0_write = (i0 < 4); m0_address = 14'h0040 + 14'(i0);
         m0_writedata = 32'hA0000000 + 32'(i0); m0_byteenable = 4'hF;
         m1_write = (i1 < 4); m1_address = 14'h0050 + 14'(i1);
         m1_writedata = 32'hB0000000 + 32'(i1); m1_byteenable = 4'hF;
         #1;
         if (i0 < 4) begin
            if (!m0_waitrequest) begin
               if (k < 8) order[k] = 1'b0;
               k++; i0++;
            end else begin
               w0++;
            end
         end
         if (i1 < 4) begin
            if (!m1_waitrequest) begin
               if (k < 8) order[k] = 1'b1;
               k++; i1++;
            end else begin
               w1++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      idle_inputs();
      check_vec("ct_cycles", 64'(cyc), 8);
      check_vec("ct_grants", 64'(k), 8);
      check_vec("ct_order", order, 8'b1010_1010);
      check_vec("ct_waits0", 64'(w0), 3);
      check_vec("ct_waits1", 64'(w1), 4);
      for (int i = 0; i < 4; i++) begin
         check_vec("ct_mem0", mem[14'h0040 + 14'(i)], 32'hA0000000 + 32'(i));
         check_vec("ct_mem1", mem[14'h0050 + 14'(i)], 32'hB0000000 + 32'(i));
      end

`ifdef OCRAM_ARB_PERF_CNT_EN
      check_vec("pc_m0", m0_grant_cnt, 4);
      check_vec("pc_m1", m1_grant_cnt, 4);
      check_vec("pc_cont", contention_cnt, 7);
      force dut.m0_grant_cnt = 32'hFFFFFFFF;
      #1;
      release dut.m0_grant_cnt;
      access(0, 1'b1, 14'h0060, 32'h0, 4'hF, w);
      check_vec("pc_wrap", m0_grant_cnt, 0);
`endif

      // Sleep after 16 idle cycles, then wake on a read
      repeat (15) @(negedge clk);
      check_vec("sl_not_yet", asleep, 0);
      check_vec("sl_clken_on", ram_clken, 1);
      @(negedge clk);
      check_vec("sl_asleep", asleep, 1);
      check_vec("sl_clken_off", ram_clken, 0);
      check_vec("sl_wait0", m0_waitrequest, 1);
      check_vec("sl_wait1", m1_waitrequest, 1);
      read_check("wake", 0, 14'h0010, 32'hDEADBEEF, 2);
      check_vec("wake_asleep", asleep, 0);
      check_vec("wake_clken", ram_clken, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end

endmodule
